// File: rtl/io_uart_tx.sv
// Byte-wide 8N1 UART transmitter behind the processor's parallel IO write port, with a write FIFO.
// Build option: define UART_TX_IRQ_EN to include the FIFO-empty interrupt (irq_o tied low otherwise).
module io_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [7:0]  BASE_ADDR    = 8'h00
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic                        io_wr,
    input  logic [7:0]                  io_addr,
    input  logic [7:0]                  data_out,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic                        irq_o,
    output logic                        overflow_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [7:0]  CTRL_ADDR = BASE_ADDR + 8'd1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    logic          wr_q;
    logic [7:0]    addr_q, data_q;
    logic          commit, data_wr, ctrl_wr, flush, ovf_clr;
    logic          push, pop, full, drop;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q;
    state_e        state_q;
    logic          tx_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic          baud_last;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_q   <= 1'b1;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wr_q <= io_wr;
            if (!io_wr) begin
                addr_q <= io_addr;
                data_q <= data_out;
            end
        end
    end

    // One commit per low pulse: the strobe's rising edge, using the last captured values.
    assign commit  = !wr_q && io_wr;
    assign data_wr = commit && (addr_q == BASE_ADDR);
    assign ctrl_wr = commit && (addr_q == CTRL_ADDR);
    assign flush   = ctrl_wr && data_q[1];
    assign ovf_clr = ctrl_wr && data_q[2];

    assign full = (count_q == CW'(FIFO_DEPTH));
    assign pop  = (state_q == S_IDLE) && (count_q != '0) && !flush;
    assign push = data_wr && (!full || pop);
    assign drop = data_wr && !push;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            rptr_d  = wptr_q;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (ovf_clr)   ovf_q <= 1'b0;
            else if (drop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= data_q;
    end

    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    if (pop) begin
                        sh_q    <= mem_q[rptr_q];
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= sh_q[0];
                        sh_q    <= sh_q >> 1;
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= sh_q[0];
                            sh_q  <= sh_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
            endcase
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_q <= data_q[0];
            irq_q <= irq_en_q && (state_q == S_IDLE) && (count_q == '0);
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    assign tx_o         = tx_q;
    assign busy_o       = (state_q != S_IDLE) || (count_q != '0);
    assign overflow_o   = ovf_q;
    assign fifo_count_o = count_q;

endmodule
